// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB pipeline register with valid/ready handshake, optional
// 2-entry skid buffer, synchronous flush and a registered EX-bypass tap.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    synchronous kill of all held entries
//   in_valid / in_ready      MEM-side handshake
//   in_wb, in_rdata,         WB control bundle, load data, ALU result,
//   in_alu, in_rd            destination register
//   out_valid / out_ready    WB-side handshake
//   out_wb, out_rdata,       held entry; out_wb reads 0 whenever out_valid=0
//   out_alu, out_rd
//   fwd_en, fwd_rd, fwd_data forwarding tap decoded from the output registers
module mem_wb_pipe #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int WB_W         = 2,
    parameter int REGWRITE_BIT = 1,
    parameter int MEMTOREG_BIT = 0,
    parameter int SKID         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [DATA_W-1:0] in_rdata,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   out_wb,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_alu,
    output logic [REG_W-1:0]  out_rd,
    output logic              fwd_en,
    output logic [REG_W-1:0]  fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);
    localparam int E_W = WB_W + 2 * DATA_W + REG_W;

    logic            out_v;
    logic [E_W-1:0]  out_e;
    logic [E_W-1:0]  in_e;
    logic [WB_W-1:0] held_wb;

    assign in_e = {in_wb, in_rdata, in_alu, in_rd};
    assign {held_wb, out_rdata, out_alu, out_rd} = out_e;
    assign out_valid = out_v;
    // Bubbles carry zero controls so the register file never sees a stray write.
    assign out_wb   = out_v ? held_wb : '0;
    assign fwd_en   = out_v & held_wb[REGWRITE_BIT] & (out_rd != '0);
    assign fwd_rd   = out_rd;
    assign fwd_data = out_wb[MEMTOREG_BIT] ? out_rdata : out_alu;

    if (SKID != 0) begin : g_skid
        logic           skid_v;
        logic [E_W-1:0] skid_e;
        // Registered ready: the skid slot absorbs the one entry that may
        // arrive in the cycle the WB side stalls.
        assign in_ready = ~skid_v;
        always_ff @(posedge clk) begin
            if (rst) begin
                out_v  <= 1'b0;
                out_e  <= '0;
                skid_v <= 1'b0;
                skid_e <= '0;
            end else if (flush) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (~out_v | out_ready) begin
                if (skid_v) begin
                    out_e  <= skid_e;
                    out_v  <= 1'b1;
                    skid_v <= 1'b0;
                end else begin
                    out_v <= in_valid;
                    if (in_valid) out_e <= in_e;
                end
            end else if (in_valid & ~skid_v) begin
                skid_e <= in_e;
                skid_v <= 1'b1;
            end
        end
    end else begin : g_single
        assign in_ready = ~out_v | out_ready;
        always_ff @(posedge clk) begin
            if (rst) begin
                out_v <= 1'b0;
                out_e <= '0;
            end else if (flush) begin
                out_v <= 1'b0;
            end else if (in_ready) begin
                out_v <= in_valid;
                if (in_valid) out_e <= in_e;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: self-checking bench for mem_wb_pipe; dut_a uses SKID=1 with
// 32-bit data, dut_b uses SKID=0 with 64-bit data, both fed the same inputs
// and each compared against a FIFO-occupancy reference model.
module tb_mem_wb_pipe;
    typedef struct packed {
        logic [1:0]  wb;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_wb;
    logic [63:0] in_rdata, in_alu;
    logic [4:0]  in_rd;

    logic        a_in_ready, a_out_valid, a_fwd_en;
    logic [1:0]  a_out_wb;
    logic [31:0] a_out_rdata, a_out_alu, a_fwd_data;
    logic [4:0]  a_out_rd, a_fwd_rd;

    logic        b_in_ready, b_out_valid, b_fwd_en;
    logic [1:0]  b_out_wb;
    logic [63:0] b_out_rdata, b_out_alu, b_fwd_data;
    logic [4:0]  b_out_rd, b_fwd_rd;

    int   errors = 0;
    int   checks = 0;
    ent_t qa[$];
    ent_t qb[$];

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(32), .SKID(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_wb(in_wb),
        .in_rdata(in_rdata[31:0]), .in_alu(in_alu[31:0]), .in_rd(in_rd),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_wb(a_out_wb),
        .out_rdata(a_out_rdata), .out_alu(a_out_alu), .out_rd(a_out_rd),
        .fwd_en(a_fwd_en), .fwd_rd(a_fwd_rd), .fwd_data(a_fwd_data)
    );

    mem_wb_pipe #(.DATA_W(64), .SKID(0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_wb(in_wb),
        .in_rdata(in_rdata), .in_alu(in_alu), .in_rd(in_rd),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_wb(b_out_wb),
        .out_rdata(b_out_rdata), .out_alu(b_out_alu), .out_rd(b_out_rd),
        .fwd_en(b_fwd_en), .fwd_rd(b_fwd_rd), .fwd_data(b_fwd_data)
    );

    // Reference: each DUT is an in-order FIFO; dut_a holds up to two entries
    // and accepts while fewer than two are held, dut_b holds one and accepts
    // when empty or when its entry leaves this cycle.
    task automatic tick();
        ent_t e;
        bit ai, ao, bi, bo;
        e  = {in_wb, in_rdata, in_alu, in_rd};
        ai = in_valid && qa.size() < 2;
        ao = qa.size() > 0 && out_ready;
        bi = in_valid && (qb.size() == 0 || out_ready);
        bo = qb.size() > 0 && out_ready;
        @(posedge clk);
        if (rst || flush) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ao) void'(qa.pop_front());
            if (ai) qa.push_back(e);
            if (bo) void'(qb.pop_front());
            if (bi) qb.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] wb, input logic [63:0] rdata,
                         input logic [63:0] alu, input logic [4:0] rd);
        in_valid = v;
        in_wb    = wb;
        in_rdata = rdata;
        in_alu   = alu;
        in_rd    = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(0, 2'b00, 64'h0, 64'h0, 5'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1, 2'b11, 64'h1234, 64'h5678, 5'd9);
        tick();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_out_wb, a_fwd_en, a_in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_a ctl got=%b exp=00001", {a_out_valid, a_out_wb, a_fwd_en, a_in_ready});
        end
        checks++;
        if ({a_out_rdata, a_out_alu, a_out_rd} !== 69'd0) begin
            errors++;
            $display("FAIL reset_a data got=%h exp=0", {a_out_rdata, a_out_alu, a_out_rd});
        end
        checks++;
        if ({b_out_valid, b_out_wb, b_fwd_en, b_in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_b ctl got=%b exp=00001", {b_out_valid, b_out_wb, b_fwd_en, b_in_ready});
        end
        checks++;
        if ({b_out_rdata, b_out_alu, b_out_rd} !== 133'd0) begin
            errors++;
            $display("FAIL reset_b data got=%h exp=0", {b_out_rdata, b_out_alu, b_out_rd});
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 2'b10, 64'(i * 3 + 100), 64'(i), 5'(i));
            #1;
            checks++;
            if (a_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_a_ready[%0d] got=%b exp=1", i, a_in_ready);
            end
            tick();
            checks++;
            if ({a_out_valid, a_out_wb, a_out_alu, a_fwd_en, a_fwd_rd, a_fwd_data} !==
                {1'b1, 2'b10, 32'(i), 1'b1, 5'(i), 32'(i)}) begin
                errors++;
                $display("FAIL stream_a[%0d] got v=%b wb=%b alu=%h en=%b rd=%0d fd=%h exp alu=fd=%0d",
                         i, a_out_valid, a_out_wb, a_out_alu, a_fwd_en, a_fwd_rd, a_fwd_data, i);
            end
            checks++;
            if ({b_out_valid, b_out_wb, b_out_alu, b_fwd_en, b_fwd_rd, b_fwd_data} !==
                {1'b1, 2'b10, 64'(i), 1'b1, 5'(i), 64'(i)}) begin
                errors++;
                $display("FAIL stream_b[%0d] got v=%b wb=%b alu=%h en=%b rd=%0d fd=%h exp alu=fd=%0d",
                         i, b_out_valid, b_out_wb, b_out_alu, b_fwd_en, b_fwd_rd, b_fwd_data, i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({a_out_valid, b_out_valid, a_out_wb, b_out_wb} !== 6'b0) begin
            errors++;
            $display("FAIL stream_drain got=%b exp=000000", {a_out_valid, b_out_valid, a_out_wb, b_out_wb});
        end
    endtask

    task automatic test_skid();
        do_reset();
        out_ready = 1'b0;
        drive(1, 2'b10, 64'h0, 64'hA, 5'd1);
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL skid_ready_A got=%b exp=1", a_in_ready);
        end
        tick();
        drive(1, 2'b10, 64'h0, 64'hB, 5'd2);
        #1;
        checks++;
        if ({a_in_ready, b_in_ready, a_out_valid, a_out_alu} !== {1'b1, 1'b0, 1'b1, 32'hA}) begin
            errors++;
            $display("FAIL skid_B_offer got a_rdy=%b b_rdy=%b v=%b alu=%h exp 1 0 1 a",
                     a_in_ready, b_in_ready, a_out_valid, a_out_alu);
        end
        tick();
        drive(1, 2'b10, 64'h0, 64'hC, 5'd3);
        #1;
        checks++;
        if ({a_in_ready, a_out_alu} !== {1'b0, 32'hA}) begin
            errors++;
            $display("FAIL skid_full got rdy=%b alu=%h exp 0 a", a_in_ready, a_out_alu);
        end
        tick();
        checks++;
        if ({a_out_valid, a_out_alu, a_out_rd} !== {1'b1, 32'hA, 5'd1}) begin
            errors++;
            $display("FAIL skid_hold got v=%b alu=%h rd=%0d exp 1 a 1", a_out_valid, a_out_alu, a_out_rd);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL skid_release_ready got=%b exp=0", a_in_ready);
        end
        tick();
        checks++;
        if ({a_out_valid, a_out_alu, a_in_ready} !== {1'b1, 32'hB, 1'b1}) begin
            errors++;
            $display("FAIL skid_B_out got v=%b alu=%h rdy=%b exp 1 b 1", a_out_valid, a_out_alu, a_in_ready);
        end
        tick();
        checks++;
        if ({a_out_valid, a_out_alu} !== {1'b1, 32'hC}) begin
            errors++;
            $display("FAIL skid_C_out got v=%b alu=%h exp 1 c", a_out_valid, a_out_alu);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL skid_empty got=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        drive(1, 2'b11, 64'h1, 64'hA, 5'd4);
        tick();
        drive(1, 2'b11, 64'h2, 64'hB, 5'd5);
        tick();
        drive(1, 2'b11, 64'h3, 64'hC, 5'd6);
        flush = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready_during got=%b exp=0", a_in_ready);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_out_wb, a_fwd_en, a_in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL flush_after got=%b exp=00001", {a_out_valid, a_out_wb, a_fwd_en, a_in_ready});
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({a_out_valid, b_out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush_dropped got=%b exp=00", {a_out_valid, b_out_valid});
        end
    endtask

    task automatic test_fwd();
        do_reset();
        out_ready = 1'b1;
        drive(1, 2'b11, 64'h55, 64'h99, 5'd0);
        tick();
        checks++;
        if ({a_out_valid, a_fwd_en, b_out_valid, b_fwd_en} !== 4'b1010) begin
            errors++;
            $display("FAIL fwd_rd0 got=%b exp=1010", {a_out_valid, a_fwd_en, b_out_valid, b_fwd_en});
        end
        drive(1, 2'b11, 64'h55, 64'h99, 5'd7);
        tick();
        checks++;
        if ({a_fwd_en, a_fwd_rd, a_fwd_data} !== {1'b1, 5'd7, 32'h55}) begin
            errors++;
            $display("FAIL fwd_a_rd7 got en=%b rd=%0d d=%h exp 1 7 55", a_fwd_en, a_fwd_rd, a_fwd_data);
        end
        checks++;
        if ({b_fwd_en, b_fwd_rd, b_fwd_data} !== {1'b1, 5'd7, 64'h55}) begin
            errors++;
            $display("FAIL fwd_b_rd7 got en=%b rd=%0d d=%h exp 1 7 55", b_fwd_en, b_fwd_rd, b_fwd_data);
        end
        drive(1, 2'b10, 64'h55, 64'h99, 5'd7);
        tick();
        checks++;
        if ({a_fwd_en, a_fwd_data, b_fwd_en, b_fwd_data} !== {1'b1, 32'h99, 1'b1, 64'h99}) begin
            errors++;
            $display("FAIL fwd_alu got a=%b/%h b=%b/%h exp 1/99", a_fwd_en, a_fwd_data, b_fwd_en, b_fwd_data);
        end
        drive(1, 2'b01, 64'h55, 64'h99, 5'd7);
        tick();
        checks++;
        if ({a_fwd_en, a_fwd_data, b_fwd_en} !== {1'b0, 32'h55, 1'b0}) begin
            errors++;
            $display("FAIL fwd_noregwrite got a=%b/%h b=%b exp 0/55 0", a_fwd_en, a_fwd_data, b_fwd_en);
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if ({a_out_wb, a_fwd_en, b_out_wb, b_fwd_en} !== 6'b0) begin
            errors++;
            $display("FAIL fwd_bubble got=%b exp=000000", {a_out_wb, a_fwd_en, b_out_wb, b_fwd_en});
        end
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        out_ready = 1'b0;
        drive(1, 2'b11, 64'h11, 64'hA, 5'd8);
        tick();
        drive(1, 2'b11, 64'h22, 64'hB, 5'd9);
        tick();
        rst = 1'b1;
        drive(1, 2'b11, 64'h33, 64'hC, 5'd10);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({a_out_valid, a_out_wb, a_fwd_en, a_in_ready, a_out_alu, a_out_rdata, a_out_rd} !==
            {5'b00001, 69'd0}) begin
            errors++;
            $display("FAIL rst_stall_a got v=%b wb=%b en=%b rdy=%b alu=%h rdata=%h rd=%0d exp all 0, rdy=1",
                     a_out_valid, a_out_wb, a_fwd_en, a_in_ready, a_out_alu, a_out_rdata, a_out_rd);
        end
        checks++;
        if ({b_out_valid, b_in_ready, b_out_alu} !== {2'b01, 64'd0}) begin
            errors++;
            $display("FAIL rst_stall_b got v=%b rdy=%b alu=%h exp 0 1 0", b_out_valid, b_in_ready, b_out_alu);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stall_empty got=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_random();
        ent_t f;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom % 150) == 0;
            flush     = ($urandom % 30) == 0;
            out_ready = ($urandom % 3) != 0;
            drive(($urandom % 4) != 0, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                  5'($urandom % 8));
            #1;
            checks++;
            if ({a_in_ready, b_in_ready} !== {qa.size() < 2, qb.size() == 0 || out_ready}) begin
                errors++;
                $display("FAIL rand_ready[%0d] got a=%b b=%b exp a=%b b=%b", n, a_in_ready, b_in_ready,
                         qa.size() < 2, qb.size() == 0 || out_ready);
            end
            tick();
            if (qa.size() == 0) begin
                checks++;
                if ({a_out_valid, a_out_wb, a_fwd_en} !== 4'b0) begin
                    errors++;
                    $display("FAIL rand_a_empty[%0d] got v=%b wb=%b en=%b exp 0", n, a_out_valid, a_out_wb, a_fwd_en);
                end
            end else begin
                f = qa[0];
                checks++;
                if ({a_out_valid, a_out_wb, a_out_rdata, a_out_alu, a_out_rd, a_fwd_en, a_fwd_data} !==
                    {1'b1, f.wb, f.rdata[31:0], f.alu[31:0], f.rd, f.wb[1] && f.rd != 0,
                     f.wb[0] ? f.rdata[31:0] : f.alu[31:0]}) begin
                    errors++;
                    $display("FAIL rand_a[%0d] got v=%b wb=%b rdata=%h alu=%h rd=%0d en=%b fd=%h exp wb=%b rdata=%h alu=%h rd=%0d",
                             n, a_out_valid, a_out_wb, a_out_rdata, a_out_alu, a_out_rd, a_fwd_en, a_fwd_data,
                             f.wb, f.rdata[31:0], f.alu[31:0], f.rd);
                end
            end
            if (qb.size() == 0) begin
                checks++;
                if ({b_out_valid, b_out_wb, b_fwd_en} !== 4'b0) begin
                    errors++;
                    $display("FAIL rand_b_empty[%0d] got v=%b wb=%b en=%b exp 0", n, b_out_valid, b_out_wb, b_fwd_en);
                end
            end else begin
                f = qb[0];
                checks++;
                if ({b_out_valid, b_out_wb, b_out_rdata, b_out_alu, b_out_rd, b_fwd_en, b_fwd_data} !==
                    {1'b1, f.wb, f.rdata, f.alu, f.rd, f.wb[1] && f.rd != 0, f.wb[0] ? f.rdata : f.alu}) begin
                    errors++;
                    $display("FAIL rand_b[%0d] got v=%b wb=%b rdata=%h alu=%h rd=%0d en=%b fd=%h exp wb=%b rdata=%h alu=%h rd=%0d",
                             n, b_out_valid, b_out_wb, b_out_rdata, b_out_alu, b_out_rd, b_fwd_en, b_fwd_data,
                             f.wb, f.rdata, f.alu, f.rd);
                end
            end
        end
        rst = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_fwd();
        test_rst_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completing the test sequence");
        $fatal(1);
    end
endmodule
